alu_op_sequencer: RTL and testbench

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_ctrl_pkg.sv | 25 ++
 rtl/alu_op_sequencer_cc_gen.sv | 18 +
 rtl/alu_op_sequencer.sv | 128 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the LC-3 ALU operate-instruction sequencer.
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    WB     = 3'd3,
    ERR    = 3'd4
  } state_t;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;

  localparam logic [1:0] ALUK_ADD  = 2'b00;
  localparam logic [1:0] ALUK_AND  = 2'b01;
  localparam logic [1:0] ALUK_NOT  = 2'b10;
  localparam logic [1:0] ALUK_PASS = 2'b11;

  function automatic logic is_legal(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_cc_gen.sv
// Condition-code generator: maps an ALU result onto the one-hot {N,Z,P} code.
module cc_gen #(
  parameter int OPW = 16
) (
  input  logic [OPW-1:0] result,
  output logic [2:0]     nzp
);

  always_comb begin
    if (result[OPW-1])
      nzp = 3'b100;
    else if (result == '0)
      nzp = 3'b010;
    else
      nzp = 3'b001;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences LC-3 ADD/AND/NOT through decode, execute and write-back,
// driving register-file selects, ALU control and condition codes.
module alu_op_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int OPW = 16
) (
  input  logic           Clk,
  input  logic           Reset_ah,
  input  logic           instr_valid,
  output logic           instr_ready,
  input  logic [15:0]    IR,
  input  logic [OPW-1:0] ALU_in,
  output logic [2:0]     SR1,
  output logic [2:0]     SR2,
  output logic [2:0]     DR,
  output logic [1:0]     ALUK,
  output logic           SR2MUX,
  output logic [OPW-1:0] SEXT_imm,
  output logic           LD_REG,
  output logic           LD_CC,
  output logic [2:0]     NZP,
  output logic           done,
  output logic           err
);

  state_t         state, state_next;
  logic [15:0]    ir_q;
  logic [OPW-1:0] result_q;
  logic [1:0]     aluk_q, aluk_dec;
  logic           sr2mux_dec;
  logic [2:0]     cc_next;

  cc_gen #(.OPW(OPW)) u_cc_gen (
    .result (result_q),
    .nzp    (cc_next)
  );

  always_ff @(posedge Clk or posedge Reset_ah) begin
    if (Reset_ah)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Each state owns exactly one group of registers, so fields stay stable until the next DECODE.
  always_ff @(posedge Clk or posedge Reset_ah) begin
    if (Reset_ah) begin
      ir_q     <= '0;
      DR       <= '0;
      SR1      <= '0;
      SR2      <= '0;
      SR2MUX   <= 1'b0;
      SEXT_imm <= '0;
      aluk_q   <= '0;
      result_q <= '0;
      NZP      <= 3'b010;
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid)
            ir_q <= IR;
        end
        DECODE: begin
          DR       <= ir_q[11:9];
          SR1      <= ir_q[8:6];
          SR2      <= ir_q[2:0];
          SR2MUX   <= sr2mux_dec;
          SEXT_imm <= {{(OPW-5){ir_q[4]}}, ir_q[4:0]};
          aluk_q   <= aluk_dec;
        end
        EXEC:    result_q <= ALU_in;
        WB:      NZP      <= cc_next;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next  = state;
    instr_ready = 1'b0;
    LD_REG      = 1'b0;
    LD_CC       = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    ALUK        = aluk_q;
    aluk_dec    = ALUK_PASS;
    sr2mux_dec  = ir_q[5];

    case (ir_q[15:12])
      OP_ADD: aluk_dec = ALUK_ADD;
      OP_AND: aluk_dec = ALUK_AND;
      OP_NOT: begin
        aluk_dec   = ALUK_NOT;
        sr2mux_dec = 1'b0;
      end
      default: ;
    endcase

    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        ALUK        = ALUK_PASS;
        if (instr_valid)
          state_next = DECODE;
      end
      DECODE:  state_next = is_legal(ir_q[15:12]) ? EXEC : ERR;
      EXEC:    state_next = WB;
      WB: begin
        LD_REG     = 1'b1;
        LD_CC      = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      ERR: begin
        err        = 1'b1;
        ALUK       = ALUK_PASS;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // While reset is held the ALU op reads as cleared rather than PASS.
    if (Reset_ah)
      ALUK = '0;
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: directed LC-3 operate instructions,
// expected responses queued at issue and checked by an independent monitor.
module tb_alu_op_sequencer;

  localparam int OPW = 16;

  logic           Clk = 1'b0;
  logic           Reset_ah;
  logic           instr_valid;
  logic           instr_ready;
  logic [15:0]    IR;
  logic [OPW-1:0] ALU_in;
  logic [2:0]     SR1, SR2, DR;
  logic [1:0]     ALUK;
  logic           SR2MUX;
  logic [OPW-1:0] SEXT_imm;
  logic           LD_REG, LD_CC;
  logic [2:0]     NZP;
  logic           done, err;

  alu_op_sequencer #(.OPW(OPW)) dut (
    .Clk         (Clk),
    .Reset_ah    (Reset_ah),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .IR          (IR),
    .ALU_in      (ALU_in),
    .SR1         (SR1),
    .SR2         (SR2),
    .DR          (DR),
    .ALUK        (ALUK),
    .SR2MUX      (SR2MUX),
    .SEXT_imm    (SEXT_imm),
    .LD_REG      (LD_REG),
    .LD_CC       (LD_CC),
    .NZP         (NZP),
    .done        (done),
    .err         (err)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    bit          isErr;
    int          acceptCyc;
    logic [2:0]  dr, sr1, sr2;
    logic [1:0]  aluk;
    logic        sr2mux;
    logic [15:0] sext;
    logic [2:0]  nzp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   lastAccept = 0;
  bit   pendDone = 0;
  bit   pendErr = 0;
  logic [2:0] pendNzp;

  function automatic exp_t mk(input bit isErr, input logic [2:0] dr, input logic [2:0] sr1,
                              input logic [2:0] sr2, input logic [1:0] aluk, input logic sr2mux,
                              input logic [15:0] sext, input logic [2:0] nzp);
    exp_t e;
    e.isErr = isErr; e.acceptCyc = 0; e.dr = dr; e.sr1 = sr1; e.sr2 = sr2;
    e.aluk = aluk; e.sr2mux = sr2mux; e.sext = sext; e.nzp = nzp;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Waits for IDLE, presents the instruction and records the cycle it is accepted on.
  task automatic applyStimulus(input logic [15:0] ir, input logic [15:0] alu, input exp_t e,
                               input bit holdValid, input bit track);
    int guard = 0;
    while (instr_ready !== 1'b1 && guard < 40) begin
      @(negedge Clk);
      guard++;
    end
    checkOutput("ready_timeout", (guard < 40) ? 32'd1 : 32'd0, 32'd1);
    IR          = ir;
    ALU_in      = alu;
    instr_valid = 1'b1;
    e.acceptCyc = cyc;
    lastAccept  = cyc;
    if (track) sb.push_back(e);
    @(negedge Clk);
    if (!holdValid) begin
      instr_valid = 1'b0;
      IR          = 16'hF00F;
    end
  endtask

  // Monitor: pops one expectation per done/err pulse, then checks the cycle after it.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (Reset_ah) begin
        pendDone = 0;
        pendErr  = 0;
      end else begin
        if (pendDone) begin
          checkOutput("nzp_after_wb", NZP, pendNzp);
          checkOutput("ld_reg_one_cycle", LD_REG, 0);
          checkOutput("aluk_idle_pass", ALUK, 2'b11);
          pendDone = 0;
        end
        if (pendErr) begin
          checkOutput("err_one_cycle", err, 0);
          checkOutput("ready_after_err", instr_ready, 1);
          pendErr = 0;
        end
        if (LD_REG || LD_CC || done)
          checkOutput("wb_strobes", {LD_REG, LD_CC, done}, 3'b111);
        if (done || err) begin
          if (sb.size() == 0) begin
            checkOutput("unexpected_completion", {done, err}, 2'b00);
          end else begin
            e = sb.pop_front();
            if (e.isErr) begin
              checkOutput("err_seen", {done, err}, 2'b01);
              checkOutput("err_latency", cyc - e.acceptCyc, 2);
              checkOutput("err_no_strobes", {LD_REG, LD_CC}, 0);
              checkOutput("err_aluk_pass", ALUK, 2'b11);
              checkOutput("err_nzp_hold", NZP, e.nzp);
              pendErr = 1;
            end else begin
              checkOutput("done_seen", {done, err}, 2'b10);
              checkOutput("done_latency", cyc - e.acceptCyc, 3);
              checkOutput("dr", DR, e.dr);
              checkOutput("sr1", SR1, e.sr1);
              checkOutput("sr2", SR2, e.sr2);
              checkOutput("aluk", ALUK, e.aluk);
              checkOutput("sr2mux", SR2MUX, e.sr2mux);
              checkOutput("sext_imm", SEXT_imm, e.sext);
              checkOutput("ready_busy", instr_ready, 0);
              pendNzp  = e.nzp;
              pendDone = 1;
            end
          end
        end
      end
    end
  end

  initial begin
    exp_t eAdd, eAnd, eNot, eIll;
    int firstAccept;
    int guard;

    eAdd = mk(0, 3'd1, 3'd2, 3'd3, 2'b00, 1'b0, 16'h0003, 3'b001);
    eAnd = mk(0, 3'd5, 3'd1, 3'd7, 2'b01, 1'b1, 16'hFFFF, 3'b010);
    eNot = mk(0, 3'd0, 3'd7, 3'd7, 2'b10, 1'b0, 16'hFFFF, 3'b100);
    eIll = mk(1, 3'd0, 3'd0, 3'd0, 2'b11, 1'b0, 16'h0000, 3'b100);

    Reset_ah    = 1'b1;
    instr_valid = 1'b0;
    IR          = 16'h0000;
    ALU_in      = '0;
    repeat (2) @(negedge Clk);
    checkOutput("rst_ready", instr_ready, 1);
    checkOutput("rst_nzp", NZP, 3'b010);
    checkOutput("rst_aluk", ALUK, 0);
    checkOutput("rst_regsel", {SR1, SR2, DR}, 0);
    checkOutput("rst_sext", SEXT_imm, 0);
    checkOutput("rst_strobes", {LD_REG, LD_CC, done, err, SR2MUX}, 0);
    Reset_ah = 1'b0;
    @(negedge Clk);

    $display("[TB] single-issue ADD / AND / NOT / illegal");
    applyStimulus(16'h1283, 16'h0005, eAdd, 0, 1);
    applyStimulus(16'h5A7F, 16'h0000, eAnd, 0, 1);
    applyStimulus(16'h91FF, 16'h8000, eNot, 0, 1);
    applyStimulus(16'h0000, 16'h1234, eIll, 0, 1);

    $display("[TB] back-to-back issue");
    applyStimulus(16'h1283, 16'h0005, eAdd, 1, 1);
    firstAccept = lastAccept;
    applyStimulus(16'h5A7F, 16'h0000, eAnd, 0, 1);
    checkOutput("b2b_interval", lastAccept - firstAccept, 4);

    $display("[TB] reset during EXEC");
    applyStimulus(16'h1283, 16'h0005, eAdd, 0, 0);
    @(negedge Clk);
    #2 Reset_ah = 1'b1;
    #1;
    checkOutput("abort_ready", instr_ready, 1);
    checkOutput("abort_nzp", NZP, 3'b010);
    checkOutput("abort_aluk", ALUK, 0);
    checkOutput("abort_regsel", {SR1, SR2, DR, SR2MUX}, 0);
    checkOutput("abort_sext", SEXT_imm, 0);
    checkOutput("abort_strobes", {LD_REG, LD_CC, done, err}, 0);
    IR          = 16'h91FF;
    ALU_in      = 16'h8000;
    instr_valid = 1'b1;
    eNot.acceptCyc = cyc;
    sb.push_back(eNot);
    #1 Reset_ah = 1'b0;
    @(negedge Clk);
    instr_valid = 1'b0;
    IR          = 16'hF00F;

    guard = 0;
    while ((sb.size() != 0 || pendDone || pendErr) && guard < 20) begin
      @(negedge Clk);
      guard++;
    end
    repeat (2) @(negedge Clk);
    checkOutput("scoreboard_drained", sb.size(), 0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
